mmc1_mapper: RTL

//  Parametrised MMC1 (SxROM) mapper; next generation after the fixed NROM "no mapper" block.

---
 rtl/mmc1_mapper_if.sv | 33 +++
 rtl/mmc1_mapper.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mmc1_mapper_if.sv
// Bus bundle between the CPU/PPU side and the MMC1 mapper.
//   ce        : CPU-cycle enable
//   flags     : cart flags, [15] = CHR is RAM
//   prg_*     : CPU address/strobe/data in, external PRG address and access permit out
//   chr_*     : PPU address in, external CHR address and CHR write permit out
//   vram_a10  : A10 for the internal 2K VRAM
//   vram_ce   : route the PPU access to internal VRAM
// The master modport is the console side, the slave modport is the mapper.
interface mmc1_mapper_if;
    logic        ce;
    logic [31:0] flags;
    logic [15:0] prg_ain;
    logic [21:0] prg_aout;
    logic        prg_read;
    logic        prg_write;
    logic [7:0]  prg_din;
    logic        prg_allow;
    logic [13:0] chr_ain;
    logic [21:0] chr_aout;
    logic        chr_allow;
    logic        vram_a10;
    logic        vram_ce;

    modport master (
        output ce, flags, prg_ain, prg_read, prg_write, prg_din, chr_ain,
        input  prg_aout, prg_allow, chr_aout, chr_allow, vram_a10, vram_ce
    );

    modport slave (
        input  ce, flags, prg_ain, prg_read, prg_write, prg_din, chr_ain,
        output prg_aout, prg_allow, chr_aout, chr_allow, vram_a10, vram_ce
    );
endinterface

// File: rtl/mmc1_mapper.sv
// MMC1 (SxROM) mapper: serial 5-bit register load port, switchable 16K PRG
// and 4K/8K CHR banking, programmable nametable mirroring and a PRG-RAM
// window at $6000-$7FFF. All address outputs are combinational.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : mmc1_mapper_if.slave (CPU/PPU address, strobes, mapped outputs)
module mmc1_mapper #(
    parameter int unsigned PRG_BANK_BITS = 4,
    parameter int unsigned CHR_BANK_BITS = 5,
    parameter logic [21:0] PRG_BASE      = 22'h000000,
    parameter logic [21:0] CHR_BASE      = 22'h100000,
    parameter logic [21:0] WRAM_BASE     = 22'h3E0000
) (
    input  logic              clk,
    input  logic              reset,
    mmc1_mapper_if.slave      bus
);
    localparam int unsigned PB = PRG_BANK_BITS;
    localparam int unsigned CB = CHR_BANK_BITS;

    // Shift register starts with a marker bit in [4]; once the marker
    // reaches [0] the next written bit completes the 5-bit value.
    localparam logic [4:0] SHIFT_EMPTY = 5'b10000;

    logic [4:0] shift_q;
    logic [4:0] ctrl_q;
    logic [4:0] chr0_q;
    logic [4:0] chr1_q;
    logic [4:0] prg_q;
    logic       wr_last_q;

    logic       wr;
    logic [4:0] load_val;

    // Consecutive-cycle writes (read-modify-write instructions) are
    // collapsed to the first one via wr_last_q.
    assign wr       = bus.ce & bus.prg_write & bus.prg_ain[15] & ~wr_last_q;
    assign load_val = {bus.prg_din[0], shift_q[4:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let load_val see updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= SHIFT_EMPTY;
            ctrl_q    <= 5'b01100;
            chr0_q    <= '0;
            chr1_q    <= '0;
            prg_q     <= '0;
            wr_last_q <= 1'b0;
        end else if (bus.ce) begin
            wr_last_q <= bus.prg_write;
            if (wr) begin
                if (bus.prg_din[7]) begin
                    // Reset of the serial port outranks a completing load.
                    shift_q <= SHIFT_EMPTY;
                    ctrl_q  <= ctrl_q | 5'b01100;
                end else if (!shift_q[0]) begin
                    shift_q <= load_val;
                end else begin
                    shift_q <= SHIFT_EMPTY;
                    unique case (bus.prg_ain[14:13])
                        2'b00:   ctrl_q <= load_val;
                        2'b01:   chr0_q <= load_val;
                        2'b10:   chr1_q <= load_val;
                        default: prg_q  <= load_val;
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // PRG mapping
    // ---------------------------------------------------------------
    logic [PB-1:0] prg_bank;
    logic [21:0]   prg_rom_addr;
    logic          wram_hit;

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        prg_bank = prg_q[PB-1:0];
        unique case (ctrl_q[3:2])
            2'b00, 2'b01: prg_bank[0] = bus.prg_ain[14];         // 32K mode
            2'b10: if (!bus.prg_ain[14]) prg_bank = '0;          // $8000 fixed to first
            default: if (bus.prg_ain[14]) prg_bank = '1;         // $C000 fixed to last
        endcase
    end

    assign prg_rom_addr  = PRG_BASE | 22'({prg_bank, bus.prg_ain[13:0]});
    assign wram_hit      = (bus.prg_ain[15:13] == 3'b011);
    assign bus.prg_aout  = wram_hit ? (WRAM_BASE | {9'b0, bus.prg_ain[12:0]})
                                    : prg_rom_addr;
    // ROM is read-only; PRG-RAM is gated by prg_reg[4] (RAM disable).
    assign bus.prg_allow = (bus.prg_ain[15] & ~bus.prg_write) | (wram_hit & ~prg_q[4]);

    // ---------------------------------------------------------------
    // CHR mapping
    // ---------------------------------------------------------------
    logic [CB-1:0] chr_bank;

    always_comb begin
        chr_bank = chr0_q[CB-1:0];
        if (ctrl_q[4]) begin
            if (bus.chr_ain[12]) chr_bank = chr1_q[CB-1:0];      // two 4K banks
        end else begin
            chr_bank[0] = bus.chr_ain[12];                       // one 8K bank
        end
    end

    assign bus.chr_aout  = CHR_BASE | 22'({chr_bank, bus.chr_ain[11:0]});
    assign bus.chr_allow = bus.flags[15];
    assign bus.vram_ce   = bus.chr_ain[13];

    // Mirroring: one-screen low, one-screen high, vertical, horizontal.
    always_comb begin
        bus.vram_a10 = 1'b0;
        unique case (ctrl_q[1:0])
            2'b00:   bus.vram_a10 = 1'b0;
            2'b01:   bus.vram_a10 = 1'b1;
            2'b10:   bus.vram_a10 = bus.chr_ain[10];
            default: bus.vram_a10 = bus.chr_ain[11];
        endcase
    end

    // Inputs and register bits that some parameterisations leave unused.
    logic unused_ok;
    assign unused_ok = ^{bus.flags[31:16], bus.flags[14:0], bus.prg_read,
                         bus.prg_din[6:1], prg_q, chr0_q, chr1_q};
endmodule
